// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT datapath defaults, mode encodings and intermediate width helper
package ntt_pkg;

    localparam int WIDTH_DEF = 18;
    localparam int Q_DEF     = 12289;

    // Two extra bits hold the sign and carry of a +/- b on canonical inputs.
    localparam int EXT_BITS  = 2;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_RSUB = 2'b10,
        MODE_PASS = 2'b11
    } mode_t;

    function automatic int raw_width(input int width);
        return width + EXT_BITS;
    endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// rtl/mod_addsub_lane.sv - combinational lane core: (a, b, mode) -> raw r, and r -> residue in [0,Q)
module mod_addsub_lane
    import ntt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int Q     = Q_DEF
) (
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic [1:0]                mode,
    output logic [WIDTH+EXT_BITS-1:0] raw,
    output logic                      range_err,
    input  logic [WIDTH+EXT_BITS-1:0] raw_in,
    output logic [WIDTH-1:0]          res
);

    localparam int RW = raw_width(WIDTH);
    localparam logic signed [RW-1:0] Q_S = RW'(Q);

    logic signed [RW-1:0] ext_a;
    logic signed [RW-1:0] ext_b;
    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] held;
    logic signed [RW-1:0] fixed;

    assign ext_a = $signed({{EXT_BITS{1'b0}}, a});
    assign ext_b = $signed({{EXT_BITS{1'b0}}, b});

    always_comb begin
        sum = ext_a;
        case (mode)
            MODE_ADD:  sum = ext_a + ext_b;
            MODE_SUB:  sum = ext_a - ext_b;
            MODE_RSUB: sum = ext_b - ext_a;
            default:   sum = ext_a;
        endcase
    end

    assign raw       = sum;
    assign range_err = (a >= WIDTH'(Q)) | (b >= WIDTH'(Q));

    // A single correction step; out-of-range operands are flagged, not fully reduced.
    assign held = $signed(raw_in);

    always_comb begin
        fixed = held;
        if (held[RW-1]) begin
            fixed = held + Q_S;
        end else if (held >= Q_S) begin
            fixed = held - Q_S;
        end
    end

    assign res = WIDTH'(fixed);

endmodule

// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - two-stage multi-lane modular add/subtract pipeline with valid/ready backpressure
module mod_addsub_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int Q     = Q_DEF,
    parameter int LANES = 4,
    parameter int TAGW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_res,
    output logic [TAGW-1:0]        out_tag,
    output logic [LANES-1:0]       out_rerr,
    output logic [31:0]            op_count
);

    localparam int RW = raw_width(WIDTH);

    logic                   adv;
    logic                   s1_valid;
    logic [LANES*RW-1:0]    s1_raw;
    logic [1:0]             s1_mode;
    logic [TAGW-1:0]        s1_tag;
    logic [LANES-1:0]       s1_rerr;

    logic [LANES*RW-1:0]    raw_w;
    logic [LANES-1:0]       rerr_w;
    logic [LANES*WIDTH-1:0] res_w;

    // Whole pipe moves as one; the output register is the only place a stall is observed.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mod_addsub_lane #(
            .WIDTH (WIDTH),
            .Q     (Q)
        ) u_lane (
            .a         (in_a[i*WIDTH +: WIDTH]),
            .b         (in_b[i*WIDTH +: WIDTH]),
            .mode      (in_mode),
            .raw       (raw_w[i*RW +: RW]),
            .range_err (rerr_w[i]),
            .raw_in    (s1_raw[i*RW +: RW]),
            .res       (res_w[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_raw    <= '0;
            s1_mode   <= MODE_ADD;
            s1_tag    <= '0;
            s1_rerr   <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_rerr  <= '0;
            op_count  <= '0;
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_raw  <= raw_w;
                    s1_mode <= in_mode;
                    s1_tag  <= in_tag;
                    s1_rerr <= rerr_w;
                end
                if (s1_valid) begin
                    out_res  <= res_w;
                    out_tag  <= s1_tag;
                    out_rerr <= s1_rerr;
                end
            end
            if (out_valid && out_ready) begin
                op_count <= op_count + 32'd1;
            end
        end
    end

    // The mode has no effect after stage 1; kept registered alongside r for debug visibility.
    logic mode_unused;
    assign mode_unused = ^s1_mode;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb/tb_mod_addsub_pipe.sv - scoreboard bench for mod_addsub_pipe
module tb_mod_addsub_pipe;

    localparam int W  = 18;
    localparam int QM = 12289;
    localparam int L  = 4;
    localparam int T  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_mode;
    logic [L*W-1:0] in_a;
    logic [L*W-1:0] in_b;
    logic [T-1:0]   in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] out_res;
    logic [T-1:0]   out_tag;
    logic [L-1:0]   out_rerr;
    logic [31:0]    op_count;

    typedef struct {
        logic [L*W-1:0] res;
        logic [T-1:0]   tag;
        logic [L-1:0]   rerr;
        int             cyc;
        bit             lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    bit   sent_done;

    mod_addsub_pipe #(.WIDTH(W), .Q(QM), .LANES(L), .TAGW(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_rerr  (out_rerr),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input int a, input int b, input logic [1:0] m);
        int r;
        case (m)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = b - a;
            default: r = a;
        endcase
        if (r < 0) r = r + QM;
        else if (r >= QM) r = r - QM;
        return W'(r);
    endfunction

    function automatic logic [L*W-1:0] rep(input logic [W-1:0] v);
        return {L{v}};
    endfunction

    // Drives one op from posedge+1, pushes its expectation when accepted, returns at posedge+1.
    task automatic send(input logic [1:0] m, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                        input logic [T-1:0] tag, input bit lat);
        exp_t e;
        bit   ok = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int l = 0; l < L; l++) begin
            e.res[l*W +: W] = model(int'(a[l*W +: W]), int'(b[l*W +: W]), m);
            e.rerr[l]       = (int'(a[l*W +: W]) >= QM) || (int'(b[l*W +: W]) >= QM);
        end
        e.tag = tag;
        e.lat = lat;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.cyc = cyc;
                sb.push_back(e);
                n_acc++;
                ok = 1;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res", out_res, e.res);
                check("tag", out_tag, e.tag);
                check("rerr", out_rerr, e.rerr);
                if (e.lat) check("latency", cyc - e.cyc, 2);
            end
        end
    end

    initial begin
        logic [L*W-1:0] ra, rb;
        in_mode   = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        do_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_rerr", out_rerr, 0);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);

        send(2'b00, rep(18'd12000), rep(18'd1000), 8'h10, 1);
        check("add_wrap_model", sb[0].res, rep(18'd711));
        send(2'b01, rep(18'd5), rep(18'd10), 8'h11, 1);
        send(2'b10, rep(18'd5), rep(18'd10), 8'h12, 1);
        send(2'b01, rep(18'd0), rep(18'd0), 8'h13, 1);
        ra = {18'd300, 18'd12289, 18'd100, 18'd0};
        rb = rep(18'd7);
        rb[2*W +: W] = 18'd0;
        send(2'b00, ra, rb, 8'h14, 1);
        drain();

        for (int i = 0; i < 100; i++) begin
            for (int l = 0; l < L; l++) begin
                ra[l*W +: W] = W'($urandom_range(QM - 1, 0));
                rb[l*W +: W] = W'($urandom_range(QM - 1, 0));
            end
            send(2'($urandom_range(3, 0)), ra, rb, T'(i), 1);
        end
        drain();

        do_reset();
        out_ready = 1'b0;
        n_acc     = 0;
        sent_done = 0;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send(2'b00, rep(W'(t)), rep(W'(100 * t)), T'(t), 0);
                sent_done = 1;
            end
        join_none
        repeat (4) @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_accepts", n_acc, 2);
        check("bp_out_valid", out_valid, 1);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_tag", out_tag, 1);
            check("bp_hold_res", out_res, rep(18'd101));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !sent_done; i++) @(posedge clk);
        check("bp_sent", sent_done, 1);
        drain();
        check("bp_op_count", op_count, 4);

        out_ready = 1'b0;
        send(2'b00, rep(18'd1), rep(18'd2), 8'hA1, 0);
        send(2'b00, rep(18'd3), rep(18'd4), 8'hA2, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_op_count", op_count, 0);
        out_ready = 1'b1;
        send(2'b01, rep(18'd2), rep(18'd12288), 8'hB1, 1);
        send(2'b10, rep(18'd9), rep(18'd4), 8'hB2, 1);
        send(2'b11, rep(18'd77), rep(18'd5), 8'hB3, 1);
        drain();
        check("post_op_count", op_count, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
